leaf_egress_buffer: RTL and testbench

//  Elastic egress stage between the leaf Stream_Flow_Control stream_out and the BFT network leaf input port.

---
 rtl/leaf_egress_buffer.sv | 132 +++++++++++++
 tb/tb_leaf_egress_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_egress_buffer.sv
// ---------------------------------------------------------------------------
// leaf_egress_buffer
//
// Elastic egress stage between the leaf flow-control stream output and the
// BFT network leaf input port. Packets the network cannot take right away
// wait in a small FIFO. A packet that finds the FIFO full (with no pop that
// cycle) is not stored; instead a one-cycle resend pulse tells the
// flow-control stage to present it again. Bit PACKET_BITS-1 is the packet
// valid flag, and an all-zero word is an idle slot.
//
// Optional feature: define LEAF_EGRESS_STATS_EN to build a saturating
// 16-bit rejected-packet counter on drop_count. When it is not defined,
// drop_count reads 16'h0000 and the port list does not change.
//
// Parameters
//   PACKET_BITS  packet width including the valid MSB
//   DEPTH_BITS   log2 of the FIFO depth (minimum 1)
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low; clears all state
//   pkt_in       packet from flow control; pushed when pkt_in[MSB] = 1
//   resend       registered 1-cycle pulse for each rejected packet
//   pkt_out      FIFO head to the network; all-zero when empty
//   pkt_out_ack  network accepted pkt_out this cycle (pop)
//   occupancy    registered entry count, 0 .. 2**DEPTH_BITS
//   drop_count   rejected-packet counter (LEAF_EGRESS_STATS_EN only)
// ---------------------------------------------------------------------------
module leaf_egress_buffer #(
  parameter int PACKET_BITS = 97,
  parameter int DEPTH_BITS  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] pkt_in,
  output logic                   resend,
  output logic [PACKET_BITS-1:0] pkt_out,
  input  logic                   pkt_out_ack,
  output logic [DEPTH_BITS:0]    occupancy,
  output logic [15:0]            drop_count
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  // Count value that means "full": a one above DEPTH_BITS zeros.
  localparam logic [DEPTH_BITS:0] FULL_COUNT = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [PACKET_BITS-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0]  wr_ptr;
  logic [DEPTH_BITS-1:0]  rd_ptr;
  logic [DEPTH_BITS:0]    count;

  logic in_valid;
  logic pop;
  logic push;
  logic reject;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    in_valid = pkt_in[PACKET_BITS-1];
    pop      = 1'b0;
    push     = 1'b0;
    reject   = 1'b0;
    if (pkt_out_ack && (count != '0)) begin
      pop = 1'b1;
    end
    if (in_valid && ((count != FULL_COUNT) || pop)) begin
      push = 1'b1;
    end
    if (in_valid && !push) begin
      reject = 1'b1;
    end
  end

  // Pointers, count and the resend pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      resend <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, regardless of statement order.
      resend <= reject;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Entries are only visible through
  // count, which does reset, so stale contents can never reach pkt_out.
  // Leaving the array out of reset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pkt_in;
    end
  end

  // The head is read combinationally from registered state, so pkt_out
  // moves only after an edge and drops to zero as soon as reset clears count.
  assign pkt_out   = (count != '0) ? mem[rd_ptr] : '0;
  assign occupancy = count;

`ifdef LEAF_EGRESS_STATS_EN
  // Saturating rejected-packet counter, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (reject && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign drop_count = 16'h0000;
`endif

  // DEPTH is kept for readability of the sizing above.
  logic unused_depth;
  assign unused_depth = (DEPTH == 0);

endmodule

// File: tb/tb_leaf_egress_buffer.sv
// ---------------------------------------------------------------------------
// tb_leaf_egress_buffer
//
// Self-checking bench for leaf_egress_buffer (PACKET_BITS=97, DEPTH_BITS=2).
// The reference model is a queue of accepted packets plus a reject tally.
// Inputs change on the falling edge and outputs are compared on the
// following falling edge, after the rising edge has settled.
// ---------------------------------------------------------------------------
module tb_leaf_egress_buffer;

  localparam int PB    = 97;
  localparam int DB    = 2;
  localparam int DEPTH = 4;

  typedef logic [PB-1:0] pkt_t;

  logic        clk = 1'b0;
  logic        reset;
  pkt_t        pkt_in;
  logic        resend;
  pkt_t        pkt_out;
  logic        pkt_out_ack;
  logic [DB:0] occupancy;
  logic [15:0] drop_count;

  leaf_egress_buffer #(.PACKET_BITS(PB), .DEPTH_BITS(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .pkt_in      (pkt_in),
    .resend      (resend),
    .pkt_out     (pkt_out),
    .pkt_out_ack (pkt_out_ack),
    .occupancy   (occupancy),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model state.
  pkt_t        q[$];
  int          rejects;
  pkt_t        exp_out;
  logic [DB:0] exp_occ;
  logic        exp_resend;
  logic [15:0] exp_drop;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic pkt_t rand_pkt(input bit valid);
    pkt_t p;
    p[31:0]  = $urandom;
    p[63:32] = $urandom;
    p[95:64] = $urandom;
    p[96]    = valid;
    return p;
  endfunction

  task automatic model_clear();
    q.delete();
    rejects    = 0;
    exp_out    = '0;
    exp_occ    = '0;
    exp_resend = 1'b0;
    exp_drop   = '0;
  endtask

  // Drive one cycle and advance the model; returns at the next falling edge.
  task automatic step(input pkt_t p, input bit ack);
    bit pop;
    bit push;
    pkt_in      = p;
    pkt_out_ack = ack;
    pop  = ack && (q.size() != 0);
    push = p[PB-1] && ((q.size() < DEPTH) || pop);
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(p);
    exp_resend = p[PB-1] && !push;
    if (exp_resend) rejects++;
`ifdef LEAF_EGRESS_STATS_EN
    exp_drop = (rejects > 65535) ? 16'hFFFF : 16'(rejects);
`else
    exp_drop = 16'h0000;
`endif
    exp_occ = (DB+1)'(q.size());
    exp_out = (q.size() != 0) ? q[0] : '0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) step('0, 1'b1);
  endtask

  task automatic test_reset();
    model_clear();
    reset = 1'b0; pkt_in = '0; pkt_out_ack = 1'b0;
    #12;
    n_cmp++;
    if (pkt_out !== '0 || resend !== 1'b0 || occupancy !== '0 || drop_count !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_hold: pkt_out=%h resend=%b occ=%0d drop=%0d want all zero",
               pkt_out, resend, occupancy, drop_count);
    end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step('0, i[0]);
      n_cmp++;
      if (pkt_out !== '0 || resend !== 1'b0 || occupancy !== '0) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: pkt_out=%h resend=%b occ=%0d want zero",
                 i, pkt_out, resend, occupancy);
      end
    end
  endtask

  task automatic test_fill_reject();
    pkt_t e;
    for (int i = 0; i < DEPTH; i++) step(rand_pkt(1'b1), 1'b0);
    n_cmp++;
    if (occupancy !== exp_occ || exp_occ !== 3'd4) begin
      n_bad++;
      $display("FAIL fill_occ: got %0d want 4 (model %0d)", occupancy, exp_occ);
    end
    e = rand_pkt(1'b1);
    step(e, 1'b0);
    n_cmp++;
    if (resend !== 1'b1) begin
      n_bad++;
      $display("FAIL reject_resend: got %b want 1", resend);
    end
    step('0, 1'b0);
    n_cmp++;
    if (resend !== 1'b0 || occupancy !== exp_occ || pkt_out !== exp_out) begin
      n_bad++;
      $display("FAIL reject_after: resend=%b occ=%0d out=%h want 0 %0d %h",
               resend, occupancy, pkt_out, exp_occ, exp_out);
    end
    n_cmp++;
    if (q.size() != DEPTH || q[DEPTH-1] === e) begin
      n_bad++;
      $display("FAIL reject_absent: model size %0d, rejected packet stored", q.size());
    end
  endtask

  task automatic test_full_push_pop();
    pkt_t e;
    e = rand_pkt(1'b1);
    step(e, 1'b1);
    n_cmp++;
    if (resend !== 1'b0 || occupancy !== 3'd4 || pkt_out !== exp_out) begin
      n_bad++;
      $display("FAIL full_push_pop: resend=%b occ=%0d out=%h want 0 4 %h",
               resend, occupancy, pkt_out, exp_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step('0, 1'b1);
      n_cmp++;
      if (pkt_out !== exp_out || occupancy !== exp_occ) begin
        n_bad++;
        $display("FAIL full_drain[%0d]: out=%h occ=%0d want %h %0d",
                 i, pkt_out, occupancy, exp_out, exp_occ);
      end
    end
    n_cmp++;
    if (occupancy !== '0 || pkt_out !== '0) begin
      n_bad++;
      $display("FAIL full_empty: occ=%0d out=%h want 0 0", occupancy, pkt_out);
    end
  endtask

  task automatic test_order();
    for (int i = 0; i < 10; i++) begin
      step(rand_pkt(1'b1), (i % 2) == 0);
      n_cmp++;
      if (pkt_out !== exp_out || occupancy !== exp_occ || resend !== exp_resend) begin
        n_bad++;
        $display("FAIL order_push[%0d]: out=%h occ=%0d rs=%b want %h %0d %b",
                 i, pkt_out, occupancy, resend, exp_out, exp_occ, exp_resend);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step('0, 1'b1);
      n_cmp++;
      if (pkt_out !== exp_out || occupancy !== exp_occ) begin
        n_bad++;
        $display("FAIL order_drain[%0d]: out=%h occ=%0d want %h %0d",
                 i, pkt_out, occupancy, exp_out, exp_occ);
      end
    end
  endtask

  task automatic test_random();
    pkt_t p;
    for (int i = 0; i < 400; i++) begin
      // Idle slots carry random low bits to show they are never written.
      p = rand_pkt($urandom_range(0, 99) < 60);
      step(p, $urandom_range(0, 99) < 45);
      n_cmp++;
      if (pkt_out !== exp_out || occupancy !== exp_occ || resend !== exp_resend ||
          drop_count !== exp_drop) begin
        n_bad++;
        $display("FAIL random[%0d]: out=%h occ=%0d rs=%b drop=%0d want %h %0d %b %0d",
                 i, pkt_out, occupancy, resend, drop_count, exp_out, exp_occ,
                 exp_resend, exp_drop);
      end
    end
    drain();
  endtask

  task automatic test_drop_count();
    for (int i = 0; i < DEPTH; i++) step(rand_pkt(1'b1), 1'b0);
`ifdef LEAF_EGRESS_STATS_EN
    for (int i = 0; i < 70000; i++) step(rand_pkt(1'b1), 1'b0);
`else
    for (int i = 0; i < 20; i++) step(rand_pkt(1'b1), 1'b0);
`endif
    n_cmp++;
    if (drop_count !== exp_drop) begin
      n_bad++;
      $display("FAIL drop_count: got %h want %h", drop_count, exp_drop);
    end
    step(rand_pkt(1'b1), 1'b0);
    n_cmp++;
`ifdef LEAF_EGRESS_STATS_EN
    if (drop_count !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL drop_saturate: got %h want ffff", drop_count);
    end
`else
    if (drop_count !== 16'h0000) begin
      n_bad++;
      $display("FAIL drop_disabled: got %h want 0000", drop_count);
    end
`endif
    n_cmp++;
    if (resend !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_resend: got %b want 1", resend);
    end
    drain();
  endtask

  task automatic test_async_reset();
    pkt_t x;
    for (int i = 0; i < 3; i++) step(rand_pkt(1'b1), 1'b0);
    n_cmp++;
    if (occupancy !== 3'd3 || pkt_out !== exp_out) begin
      n_bad++;
      $display("FAIL areset_pre: occ=%0d out=%h want 3 %h", occupancy, pkt_out, exp_out);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (pkt_out !== '0 || occupancy !== '0 || resend !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_async: out=%h occ=%0d rs=%b want 0 0 0",
               pkt_out, occupancy, resend);
    end
    model_clear();
    @(negedge clk) reset = 1'b1;
    n_cmp++;
    if (occupancy !== '0 || drop_count !== 16'h0) begin
      n_bad++;
      $display("FAIL areset_release: occ=%0d drop=%0d want 0 0", occupancy, drop_count);
    end
    x = rand_pkt(1'b1);
    step(x, 1'b0);
    n_cmp++;
    if (pkt_out !== x || occupancy !== 3'd1) begin
      n_bad++;
      $display("FAIL areset_next: out=%h occ=%0d want %h 1", pkt_out, occupancy, x);
    end
  endtask

  initial begin
    test_reset();
    test_fill_reject();
    test_full_push_pop();
    test_order();
    test_random();
    test_drop_count();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
